// File: rtl/video_timing_receiver_if.sv
// Sample stream into the video timing receiver and its recovered-position / lock / frame-count outputs.
interface video_timing_receiver_if;
  logic        ce_i;
  logic        de_i;
  logic        pix_i;
  logic        valid_o;
  logic        pix_o;
  logic [9:0]  col_o;
  logic [9:0]  row_o;
  logic        sof_o;
  logic        locked_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic        frame_done_o;
  logic [18:0] pix_count_o;

  modport master (
    output ce_i, de_i, pix_i,
    input  valid_o, pix_o, col_o, row_o, sof_o, locked_o, err_o, err_code_o,
           frame_done_o, pix_count_o
  );

  modport slave (
    input  ce_i, de_i, pix_i,
    output valid_o, pix_o, col_o, row_o, sof_o, locked_o, err_o, err_code_o,
           frame_done_o, pix_count_o
  );
endinterface

// File: rtl/video_timing_receiver.sv
// Recovers pixel position from de alone, checks line/frame geometry to declare lock,
// and counts lit active pixels per good frame.
module video_timing_receiver #(
  parameter logic [9:0] NumColTotal  = 10'd800,
  parameter logic [9:0] NumColActive = 10'd640,
  parameter logic [9:0] NumRowActive = 10'd480
) (
  input logic                    clk_i,
  input logic                    rst_i,
  video_timing_receiver_if.slave vif
);
  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t      r_state, w_state_next;
  logic        r_de_prev;
  logic [9:0]  r_gap, r_col, r_row;
  logic [18:0] r_acc;

  logic        r_valid, r_pix, r_sof, r_locked, r_err, r_frame_done;
  logic [9:0]  r_col_o, r_row_o;
  logic [1:0]  r_err_code;
  logic [18:0] r_pix_count;

  logic        w_rise, w_fall, w_vblank, w_line_rise;
  logic        w_width_err, w_extra_err, w_height_err, w_err, w_good_vb;
  logic [1:0]  w_code;
  logic [9:0]  w_gap_next, w_col_next, w_row_next;
  logic [18:0] w_acc_next;

  // A rise after at least one full line of blanking marks the start of a frame.
  assign w_rise       = vif.de_i & ~r_de_prev;
  assign w_fall       = ~vif.de_i & r_de_prev;
  assign w_vblank     = w_rise & (r_gap >= NumColTotal);
  assign w_line_rise  = w_rise & ~w_vblank;
  assign w_width_err  = w_fall & (({1'b0, r_col} + 11'd1) != {1'b0, NumColActive});
  assign w_extra_err  = w_line_rise & (r_row == (NumRowActive - 10'd1));
  assign w_height_err = w_vblank & ((r_row + 10'd1) != NumRowActive);

  assign w_gap_next = vif.de_i ? 10'd0 : ((r_gap == 10'h3FF) ? r_gap : r_gap + 10'd1);
  assign w_col_next = w_rise ? 10'd0 :
                      ((vif.de_i && r_col != 10'h3FF) ? r_col + 10'd1 : r_col);
  assign w_row_next = w_vblank ? 10'd0 :
                      ((w_line_rise && r_row != 10'h3FF) ? r_row + 10'd1 : r_row);

  always_comb begin
    w_state_next = r_state;
    w_code       = 2'b00;
    w_good_vb    = 1'b0;
    case (r_state)
      SEARCH: begin
        if (w_vblank) w_state_next = ALIGN;
      end
      ALIGN, LOCKED: begin
        if (w_width_err)       w_code = 2'b01;
        else if (w_extra_err)  w_code = 2'b11;
        else if (w_height_err) w_code = 2'b10;
        if (w_code != 2'b00) begin
          w_state_next = SEARCH;
        end else if (w_vblank) begin
          w_good_vb    = 1'b1;
          w_state_next = LOCKED;
        end
      end
      default: w_state_next = SEARCH;
    endcase
  end

  assign w_err = (w_code != 2'b00);

  // The frame-opening sample belongs to the new frame, so the accumulator restarts with it.
  always_comb begin
    w_acc_next = r_acc;
    if (r_state == SEARCH) begin
      if (w_vblank) w_acc_next = {18'd0, vif.pix_i};
    end else if (w_good_vb) begin
      w_acc_next = {18'd0, vif.pix_i};
    end else if (vif.de_i && vif.pix_i && r_acc != 19'h7FFFF) begin
      w_acc_next = r_acc + 19'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          r_state <= SEARCH;
    else if (vif.ce_i)  r_state <= w_state_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_de_prev    <= 1'b0;
      r_gap        <= 10'd0;
      r_col        <= 10'd0;
      r_row        <= 10'd0;
      r_acc        <= 19'd0;
      r_valid      <= 1'b0;
      r_pix        <= 1'b0;
      r_col_o      <= 10'd0;
      r_row_o      <= 10'd0;
      r_sof        <= 1'b0;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= 2'b00;
      r_frame_done <= 1'b0;
      r_pix_count  <= 19'd0;
    end else begin
      r_valid      <= 1'b0;
      r_sof        <= 1'b0;
      r_err        <= 1'b0;
      r_frame_done <= 1'b0;
      if (vif.ce_i) begin
        r_de_prev    <= vif.de_i;
        r_gap        <= w_gap_next;
        r_col        <= w_col_next;
        r_row        <= w_row_next;
        r_acc        <= w_acc_next;
        r_valid      <= vif.de_i & (w_state_next == LOCKED);
        r_pix        <= vif.pix_i;
        r_col_o      <= w_col_next;
        r_row_o      <= w_row_next;
        r_sof        <= w_good_vb;
        r_locked     <= (w_state_next == LOCKED);
        r_err        <= w_err;
        r_frame_done <= w_good_vb;
        if (w_err)     r_err_code  <= w_code;
        if (w_good_vb) r_pix_count <= r_acc;
      end
    end
  end

  assign vif.valid_o      = r_valid;
  assign vif.pix_o        = r_pix;
  assign vif.col_o        = r_col_o;
  assign vif.row_o        = r_row_o;
  assign vif.sof_o        = r_sof;
  assign vif.locked_o     = r_locked;
  assign vif.err_o        = r_err;
  assign vif.err_code_o   = r_err_code;
  assign vif.frame_done_o = r_frame_done;
  assign vif.pix_count_o  = r_pix_count;
endmodule

// File: tb/tb_video_timing_receiver.sv
// Scoreboard bench: a sample-index reference model queues expected outputs, a monitor compares every clock.
module tb_video_timing_receiver;
  localparam int TOT  = 12;
  localparam int ACT  = 8;
  localparam int ROWS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  video_timing_receiver_if vif ();

  video_timing_receiver #(
    .NumColTotal (10'd12),
    .NumColActive(10'd8),
    .NumRowActive(10'd4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .vif  (vif.slave)
  );

  typedef struct {
    bit valid, pix, sof, locked, err, fd, fresh;
    int col, row, code, pc, sample;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: positions derived from absolute sample indices of the last de rise / de sample.
  int   m_n, m_last_de, m_rise_at, m_col, m_row, m_st, m_acc;
  bit   m_dep, m_fresh;
  exp_t m_prev;

  task automatic model_reset();
    m_n = 0; m_last_de = -1; m_rise_at = 0; m_col = 0; m_row = 0;
    m_st = 0; m_acc = 0; m_dep = 1'b0; m_fresh = 1'b1;
    m_prev = '{default: 0};
  endtask

  task automatic model_step(input bit ce, input bit de, input bit pix);
    exp_t e;
    int   gap, run, code;
    bit   rise, fall, vb, good;
    e = m_prev;
    if (!ce) begin
      e.valid = 0; e.sof = 0; e.err = 0; e.fd = 0;
    end else begin
      gap  = m_n - m_last_de - 1;
      if (gap > 1023) gap = 1023;
      rise = de && !m_dep;
      fall = !de && m_dep;
      vb   = rise && gap >= TOT;
      run  = m_n - m_rise_at;
      code = 0;
      if (m_st != 0) begin
        if (fall && run != ACT)                  code = 1;
        else if (rise && !vb && m_row == ROWS-1) code = 3;
        else if (vb && m_row + 1 != ROWS)        code = 2;
      end
      if (rise) m_rise_at = m_n;
      if (de) begin
        m_col = m_n - m_rise_at;
        if (m_col > 1023) m_col = 1023;
        m_last_de = m_n;
      end
      if (vb) m_row = 0;
      else if (rise && m_row < 1023) m_row++;
      good = vb && m_st != 0 && code == 0;
      if (good) e.pc = m_acc;
      if (m_st == 0) begin
        if (vb) begin m_st = 1; m_acc = int'(pix); end
      end else if (code != 0) begin
        m_st = 0;
      end else if (good) begin
        m_st = 2; m_acc = int'(pix);
      end else if (de && pix && m_acc < 524287) begin
        m_acc++;
      end
      e.valid  = de && m_st == 2;
      e.pix    = pix;
      e.col    = m_col;
      e.row    = m_row;
      e.sof    = good;
      e.fd     = good;
      e.locked = (m_st == 2);
      e.err    = (code != 0);
      if (code != 0) e.code = code;
      e.sample = m_n;
      m_dep = de;
      m_n++;
    end
    e.fresh = m_fresh;
    m_fresh = 1'b0;
    q.push_back(e);
    m_prev = e;
    m_prev.fresh = 1'b0;
  endtask

  // Monitor: every clock after reset has exactly one queued expectation.
  exp_t        mon_e;
  logic [46:0] got_v, exp_v;
  int          first_lock = -1;
  int          last_pc = -1;

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      got_v = {vif.valid_o, vif.pix_o, vif.sof_o, vif.locked_o, vif.err_o, vif.frame_done_o,
               vif.col_o, vif.row_o, vif.err_code_o, vif.pix_count_o};
      exp_v = {mon_e.valid, mon_e.pix, mon_e.sof, mon_e.locked, mon_e.err, mon_e.fd,
               10'(mon_e.col), 10'(mon_e.row), 2'(mon_e.code), 19'(mon_e.pc)};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL outputs sample=%0d got v%b p%b sof%b lk%b err%b fd%b col%0d row%0d code%0d pc%0d expected v%b p%b sof%b lk%b err%b fd%b col%0d row%0d code%0d pc%0d",
                 mon_e.sample, vif.valid_o, vif.pix_o, vif.sof_o, vif.locked_o, vif.err_o,
                 vif.frame_done_o, vif.col_o, vif.row_o, vif.err_code_o, vif.pix_count_o,
                 mon_e.valid, mon_e.pix, mon_e.sof, mon_e.locked, mon_e.err, mon_e.fd,
                 mon_e.col, mon_e.row, mon_e.code, mon_e.pc);
      end
      if (mon_e.fresh) first_lock = -1;
      if (vif.locked_o && first_lock < 0) first_lock = mon_e.sample;
      if (vif.frame_done_o) begin
        last_pc = int'(vif.pix_count_o);
        $display("frame_done sample=%0d pix_count=%0d", mon_e.sample, vif.pix_count_o);
      end
      if (vif.err_o) $display("error sample=%0d code=%0d", mon_e.sample, vif.err_code_o);
    end
  end

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  // Stimulus
  int ce_mode = 0;  // 0: every cycle, 1: toggle 1/0, 2: random gaps
  bit pmode   = 0;  // single lit pixel at (row 2, col 3)

  task automatic drive(input bit ce, input bit de, input bit pix);
    @(negedge clk);
    vif.ce_i = ce; vif.de_i = de; vif.pix_i = pix;
    model_step(ce, de, pix);
  endtask

  task automatic send(input bit de, input bit pix);
    if (ce_mode == 2) repeat ($urandom_range(0, 2)) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drive(1'b1, de, pix);
    if (ce_mode == 1) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic send_frame(input int nlines, input int badline, input int badrun);
    int run;
    bit p;
    for (int r = 0; r < nlines; r++) begin
      run = (r == badline) ? badrun : ACT;
      for (int i = 0; i < TOT; i++) begin
        p = pmode ? (r == 2 && i == 3) : 1'($urandom_range(0, 1));
        send(i < run, p);
      end
    end
    for (int i = 0; i < 2 * TOT; i++) send(1'b0, pmode ? 1'b0 : 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    vif.ce_i = 1'b0; vif.de_i = 1'b0; vif.pix_i = 1'b0;
    #1;
    check_int("reset_outputs",
              int'({vif.valid_o, vif.pix_o, vif.sof_o, vif.locked_o, vif.err_o, vif.frame_done_o,
                    vif.col_o, vif.row_o, vif.err_code_o, vif.pix_count_o} != 47'd0), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int nl, bl;
    vif.ce_i = 1'b0; vif.de_i = 1'b0; vif.pix_i = 1'b0;
    model_reset();
    do_reset();

    // Clean stream from reset: lock on sample 144.
    repeat (3) send_frame(ROWS, -1, 0);
    check_int("lock_sample_ce1", first_lock, 144);

    // Single lit pixel frame.
    pmode = 1;
    send_frame(ROWS, -1, 0);
    pmode = 0;
    send_frame(ROWS, -1, 0);
    check_int("single_pixel_count", last_pc, 1);

    // Short line, then relock.
    send_frame(ROWS, 1, ACT - 1);
    repeat (3) send_frame(ROWS, -1, 0);

    // Extra line, relock, short frame, relock.
    send_frame(ROWS + 1, -1, 0);
    repeat (2) send_frame(ROWS, -1, 0);
    send_frame(ROWS - 1, -1, 0);
    repeat (3) send_frame(ROWS, -1, 0);

    // ce toggling from reset: lock still on sample 144.
    do_reset();
    ce_mode = 1;
    repeat (3) send_frame(ROWS, -1, 0);
    check_int("lock_sample_ce_toggle", first_lock, 144);

    // Reset mid-frame while locked.
    for (int i = 0; i < 2 * TOT; i++) send(i % TOT < ACT, 1'($urandom_range(0, 1)));
    do_reset();
    ce_mode = 0;
    repeat (3) send_frame(ROWS, -1, 0);

    // Random frames, random ce gaps, occasional geometry faults.
    ce_mode = 2;
    for (int f = 0; f < 12; f++) begin
      nl = (f % 4 == 3) ? int'($urandom_range(ROWS - 1, ROWS + 1)) : ROWS;
      bl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
      send_frame(nl, bl, int'($urandom_range(ACT - 2, ACT + 1)));
    end
    ce_mode = 0;
    repeat (4) send(1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check_int("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/video_timing_receiver.md
Name: video_timing_receiver

Overview:
- Sink-side counterpart of the pattern source: consumes the registered 1-bit video stream (de, pix, qualified by ce) and recovers pixel position from de alone.
- Checks line width and frame height against the expected active geometry and declares lock.
- Counts lit pixels per frame, giving a self-checking loopback target and an on-chip link monitor.

Parameters:
- NumColTotal, 10'd800: total samples per line; the vblank detection threshold.
- NumColActive, 10'd640: expected de-high run length per line.
- NumRowActive, 10'd480: expected de-active lines per frame.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- ce_i  in  1  sample qualifier; only cycles with ce_i=1 are samples
- de_i  in  1  data enable from the source
- pix_i  in  1  pixel value, meaningful while de_i=1
- valid_o  out  1  registered; sample is active video and the receiver is LOCKED
- pix_o  out  1  registered copy of pix_i
- col_o  out  10  column of the current output sample
- row_o  out  10  row of the current output sample
- sof_o  out  1  1-cycle pulse on the first active sample of a frame (row 0, col 0)
- locked_o  out  1  level, high in LOCKED
- err_o  out  1  1-cycle error pulse
- err_code_o  out  2  held until next error: 01 width, 10 height, 11 extra line
- frame_done_o  out  1  1-cycle pulse when pix_count_o updates
- pix_count_o  out  19  number of pix_i=1 active samples in the last good frame

Behaviour:
- Clock and reset: one clock, clk_i; rst_i is asynchronous, active-high.
- Reset values: all outputs 0; state SEARCH; all counters 0; de_prev 0.
- ce_i=0: all state holds; valid_o, sof_o, err_o and frame_done_o are driven 0.
- Latency: exactly 1 clock from sample (ce_i=1) to outputs.
- Edge detection: rise = de_i & !de_prev; fall = !de_i & de_prev; de_prev updates on samples only.
- gap counter:
  - 10 bits; increments on each de_i=0 sample, saturating at 1023.
  - Cleared on each de_i=1 sample.
- Vblank rise: a rise with gap >= NumColTotal. Any other rise is a line rise.
- col counter: set to 0 on a rise, +1 per following de sample, saturating at 1023.
- row counter:
  - Set to 0 on a vblank rise; +1 on a line rise.
  - If a line rise occurs with row = NumRowActive-1, it is an extra-line error.
- Width check: on fall, col+1 != NumColActive is a width error.
- Height check: on a vblank rise in ALIGN or LOCKED, (row+1) != NumRowActive is a height error.
- State machine:
  - SEARCH:
    - Ignores all checks.
    - On a vblank rise: go to ALIGN, clear the frame error flag, clear the pixel accumulator.
  - ALIGN:
    - Measures one full frame.
    - Any width or extra-line error goes to SEARCH with err_o.
    - On the next vblank rise:
      - If height is OK and no error, go to LOCKED, assert sof_o for this sample, latch pix_count_o, pulse frame_done_o.
      - Otherwise go to SEARCH with err_o.
  - LOCKED:
    - valid_o = de sample; col_o/row_o reflect the counters for that sample; sof_o on a vblank rise.
    - Any error goes to SEARCH with err_o; locked_o falls the same cycle; valid_o for the erroring sample is 0.
- Pixel accumulator:
  - 19 bits; +1 on each de sample with pix_i=1 in ALIGN/LOCKED.
  - Saturates at 2^19-1.
  - On a good vblank rise: copied to pix_count_o, then restarts, counting the current sample.
- Simultaneous events: when a width error and a vblank rise coincide, error handling takes priority and no frame_done_o is issued.
- Reset mid-frame: immediate return to SEARCH. Because the gap counter restarts at 0, lock requires a fresh vblank plus one full frame.

Test Plan (NumColTotal=12, NumColActive=8, NumRowActive=4, 6 lines/frame):
- Clean stream from reset, ce_i=1, de_i active from cycle 0 → first rise ignored; vblank rise at sample 72 → ALIGN; at sample 144 → locked_o=1, sof_o=1, frame_done_o=1.
- Locked; pix_i=1 only at (row 2, col 3) → valid_o/col_o=3/row_o=2/pix_o=1 one clock after that sample; next frame_done_o has pix_count_o=1.
- Locked; one line with a 7-sample de run → on the fall: err_o=1, err_code_o=01, locked_o=0, state SEARCH; relock after 2 further vblanks.
- Locked; frame with 5 active lines → extra-line error err_code_o=11 on the 5th line rise; frame with 3 lines → err_code_o=10 at the vblank rise.
- ce_i toggling 1/0 every cycle with the same sample sequence → identical output values on ce cycles; strobes never high while ce_i=0; lock reached at sample 144.
- rst_i pulsed mid-frame while locked → all outputs 0 asynchronously; no valid_o until the second vblank after release.
